// File: rtl/param_regfile.sv
// DEPTH x WIDTH register file: masked clear/load/inc/dec with sticky wrap flags, two combinational read ports.
// Optional build macro REGFILE_SATURATE_EN: counters saturate instead of wrapping (flags still set).

module param_regfile_cell #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Sel,
  input  logic [1:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic             Flag
);
  logic allOnes, allZero;
  assign allOnes = &Q;
  assign allZero = ~|Q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      Q    <= '0;
      Flag <= 1'b0;
    end else if (Sel) begin
      unique case (FunSel)
        2'b00: begin Q <= '0; Flag <= 1'b0; end
        2'b01: begin Q <= I;  Flag <= 1'b0; end
        2'b10: begin
`ifdef REGFILE_SATURATE_EN
          Q <= allOnes ? Q : Q + WIDTH'(1);
`else
          Q <= Q + WIDTH'(1);
`endif
          Flag <= Flag | allOnes;
        end
        default: begin
`ifdef REGFILE_SATURATE_EN
          Q <= allZero ? Q : Q - WIDTH'(1);
`else
          Q <= Q - WIDTH'(1);
`endif
          Flag <= Flag | allZero;
        end
      endcase
    end
  end
endmodule

module param_regfile #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int SELW  = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             E,
  input  logic [1:0]       FunSel,
  input  logic [DEPTH-1:0] RegSel,
  input  logic [WIDTH-1:0] I,
  input  logic [SELW-1:0]  OutASel,
  input  logic [SELW-1:0]  OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             OutAFlag,
  output logic             OutBFlag,
  output logic [DEPTH-1:0] FlagVec,
  output logic             AnyFlag
);
  logic [DEPTH-1:0][WIDTH-1:0] regQ;

  for (genvar k = 0; k < DEPTH; k++) begin : gReg
    param_regfile_cell #(.WIDTH(WIDTH)) uCell (
      .CLK   (CLK),
      .Reset (Reset),
      .Sel   (E & RegSel[k]),
      .FunSel(FunSel),
      .I     (I),
      .Q     (regQ[k]),
      .Flag  (FlagVec[k])
    );
  end

  assign AnyFlag = |FlagVec;

  // Indices >= DEPTH match no register and read back as zero.
  always_comb begin
    OutA     = '0;
    OutB     = '0;
    OutAFlag = 1'b0;
    OutBFlag = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (OutASel == SELW'(k)) begin
        OutA     = regQ[k];
        OutAFlag = FlagVec[k];
      end
      if (OutBSel == SELW'(k)) begin
        OutB     = regQ[k];
        OutBFlag = FlagVec[k];
      end
    end
  end
endmodule

// File: doc/param_regfile.md
# param_regfile

Parametrised general-purpose register file, the next generation of the fixed 8-bit, 4-entry register file and single register. It holds DEPTH registers of WIDTH bits. Each cycle it clears, loads, increments or decrements any subset of registers selected by a one-hot mask. Per-register sticky wrap flags record counter overflow and underflow. Two independent combinational read ports feed the ALU A and B operand muxes.

## Interface
- WIDTH, 8, register width in bits (≥2)
- DEPTH, 4, number of registers (2..16)
- SELW, $clog2(DEPTH), read-select width (derived; not overridden)

- CLK  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- E  in  1  global write enable; 0 = hold all registers and flags
- FunSel  in  2  00 clear, 01 load I, 10 increment, 11 decrement
- RegSel  in  DEPTH  active-high mask; bit k selects register Rk for the FunSel operation
- I  in  WIDTH  load data
- OutASel  in  SELW  read port A index
- OutBSel  in  SELW  read port B index
- OutA  out  WIDTH  contents of R[OutASel]
- OutB  out  WIDTH  contents of R[OutBSel]
- OutAFlag  out  1  sticky wrap flag of R[OutASel]
- OutBFlag  out  1  sticky wrap flag of R[OutBSel]
- FlagVec  out  DEPTH  all sticky wrap flags, bit k = Rk
- AnyFlag  out  1  OR of FlagVec

## Operation
- State: R0..R(DEPTH-1), WIDTH bits each; F0..F(DEPTH-1), 1 bit each.
- Update rule, evaluated on each rising CLK edge, in priority order:
  - Reset=1: all Rk=0, all Fk=0. Overrides E, FunSel and RegSel.
  - E=0: all Rk and Fk hold.
  - E=1: every register with RegSel[k]=1 applies FunSel in the same cycle. Registers with RegSel[k]=0 hold.
- FunSel effects on a selected register:
  - Clear: Rk=0, Fk=0.
  - Load: Rk=I, Fk=0.
  - Increment: Rk=Rk+1, truncated to WIDTH bits. Fk sets to 1 if Rk was all-ones; otherwise Fk holds.
  - Decrement: Rk=Rk-1, truncated to WIDTH bits. Fk sets to 1 if Rk was 0; otherwise Fk holds.
- Sticky flags clear only via Reset, Clear or Load of that register.
- RegSel=0 with E=1 is a legal no-op.
- Multi-bit RegSel is legal. All selected registers update identically and independently (e.g., two counters decrement together).
- Read ports:
  - Purely combinational from stored state; no write-through bypass.
  - OutASel and OutBSel may be equal; both ports then show the same register.
- Out-of-range index (OutxSel ≥ DEPTH, possible when DEPTH is not a power of 2): OutX=0, OutXFlag=0.

## Timing
- Write latency 1 cycle: a value written at edge n appears on OutA/OutB after edge n, combinationally.
- Read latency 0 cycles from an OutxSel change.
- Read during write: the port shows the old value until the edge.
- Reset values: OutA=0, OutB=0, OutAFlag=0, OutBFlag=0, FlagVec=0, AnyFlag=0 from the first edge with Reset=1.
- Reset asserted during a multi-cycle counting sequence: the counters are 0 after that edge. Counting resumes from 0 on the first edge with Reset=0, E=1.
- No handshake: E, FunSel and RegSel are sampled every edge.

## Configuration
- Macro REGFILE_SATURATE_EN.
  - Defined: increment of all-ones holds all-ones; decrement of 0 holds 0. Fk still sets on the attempted wrap.
  - Undefined (default): modular wrap as described under Operation.
- Read ports, Reset and flag behaviour are otherwise identical in both builds.

## Test plan
- Reset, then E=1, FunSel=01, RegSel=4'b1111, I=8'hAA for 1 cycle -> OutA=OutB=8'hAA for every OutASel/OutBSel 0..3; FlagVec=0.
- Load R2=8'hFE, then 3 increments on RegSel=4'b0100:
  - Wrap build: R2 sequence FF, 00, 01; F2=1 from the 00 cycle onward; AnyFlag=1.
  - REGFILE_SATURATE_EN build: sequence FF, FF, FF; F2=1.
- Load R0=8'h00 and R1=8'h05, then 1 decrement on RegSel=4'b0011 -> R0=8'hFF with F0=1; R1=8'h04 with F1=0; R2 and R3 unchanged.
- E=0 with FunSel=11, RegSel=4'b1111 for 4 cycles -> all registers and flags unchanged. Then Load on R0 -> F0 clears and the other flags keep their values.
- Increment R3 for 5 cycles, asserting Reset in the 3rd cycle together with E=1 -> R3=0 after that edge, then R3=1 and R3=2 on the next two edges; F3=0 throughout.
- WIDTH=16, DEPTH=6, OutASel=7 -> OutA=0, OutAFlag=0. Load R5=16'h1234 -> visible on OutB with OutBSel=5 only after the edge, not before.
